multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32 datapath. Fetches, decodes and executes one instruction at a time by stepping an FSM that drives the shared `control_t` bundle plus PC/IR/address-mux enables. Handles a single-port memory with a ready handshake. Sits between the instruction register / ALU zero flag and the register file, ALU and memory interface.

---
 rtl/multicycle_ctrl_pkg.sv | 78 +++++++
 rtl/multicycle_ctrl_alu_decoder.sv | 62 ++++++
 rtl/multicycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared control definitions for the multi-cycle RV32 sequencer.
// IMM_ALU_EN adds the OP-IMM class and the EXEC_I state.
package control_defs;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_sel_e;

    typedef struct packed {
        logic     alu_src;
        logic     mem_to_reg;
        logic     reg_write;
        logic     mem_read;
        logic     mem_write;
        logic     branch;
        alu_sel_e alu_sel;
    } control_t;

    localparam control_t CTRL_DEFAULT = '{
        alu_src:    1'b0,
        mem_to_reg: 1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        branch:     1'b0,
        alu_sel:    ALU_ADD
    };

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_ADDR,
        EXEC_BR,
        MEM_RD,
        MEM_WR,
        WB_R,
        WB_MEM,
`ifdef IMM_ALU_EN
        EXEC_I,
`endif
        TRAP
    } ctrl_state_e;

    typedef enum logic [2:0] {
        OPC_R,
        OPC_LOAD,
        OPC_STORE,
        OPC_BRANCH,
        OPC_IMM,
        OPC_NONE
    } op_class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    function automatic op_class_e classify(input logic [6:0] opcode);
        op_class_e c;
        case (opcode)
            OP_R:      c = OPC_R;
            OP_LOAD:   c = OPC_LOAD;
            OP_STORE:  c = OPC_STORE;
            OP_BRANCH: c = OPC_BRANCH;
`ifdef IMM_ALU_EN
            OP_IMM:    c = OPC_IMM;
`endif
            default:   c = OPC_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational decode of {op class, funct3, funct7_5} into ALU select and legality.
// IMM_ALU_EN enables the addi/ori/andi decodes.
module alu_decoder
    import control_defs::*;
(
    input  op_class_e  op_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_sel_e   alu_sel,
    output logic       legal
);

    always_comb begin
        alu_sel = ALU_ADD;
        legal   = 1'b0;
        case (op_class)
            OPC_R: begin
                case (funct3)
                    3'b000: begin
                        legal   = 1'b1;
                        alu_sel = funct7_5 ? ALU_SUB : ALU_ADD;
                    end
                    3'b111: begin
                        legal   = 1'b1;
                        alu_sel = ALU_AND;
                    end
                    3'b110: begin
                        legal   = 1'b1;
                        alu_sel = ALU_OR;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD, OPC_STORE: legal = (funct3 == 3'b010);
            OPC_BRANCH: begin
                legal   = (funct3 == 3'b000);
                alu_sel = ALU_SUB;
            end
`ifdef IMM_ALU_EN
            OPC_IMM: begin
                case (funct3)
                    3'b000: begin
                        legal   = 1'b1;
                        alu_sel = ALU_ADD;
                    end
                    3'b110: begin
                        legal   = 1'b1;
                        alu_sel = ALU_OR;
                    end
                    3'b111: begin
                        legal   = 1'b1;
                        alu_sel = ALU_AND;
                    end
                    default: legal = 1'b0;
                endcase
            end
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer driving the shared control bundle.
// IMM_ALU_EN adds OP-IMM instructions executed through EXEC_I.
module multicycle_ctrl
    import control_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output control_t   ctrl,
    output logic       ir_write,
    output logic       pc_inc,
    output logic       pc_branch,
    output logic       iord,
    output logic       instr_done,
    output logic       illegal
);

    ctrl_state_e state_q, state_d;
    op_class_e   op_class_q;
    alu_sel_e    alu_sel_q;
    op_class_e   dec_class;
    alu_sel_e    dec_alu_sel;
    logic        dec_legal;

    assign dec_class = classify(opcode);

    alu_decoder u_alu_decoder (
        .op_class (dec_class),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_sel  (dec_alu_sel),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Op class and ALU select are captured once so EXEC states need not re-decode IR.
    always_ff @(posedge clk) begin
        if (state_q == DECODE) begin
            op_class_q <= dec_class;
            alu_sel_q  <= dec_alu_sel;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl       = CTRL_DEFAULT;
        ir_write   = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        iord       = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        // Reset forces every output to its default regardless of the current state.
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    ctrl.mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_inc   = 1'b1;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    if (!dec_legal) begin
                        state_d = TRAP;
                    end else begin
                        case (dec_class)
                            OPC_R:               state_d = EXEC_R;
                            OPC_LOAD, OPC_STORE: state_d = EXEC_ADDR;
                            OPC_BRANCH:          state_d = EXEC_BR;
`ifdef IMM_ALU_EN
                            OPC_IMM:             state_d = EXEC_I;
`endif
                            default:             state_d = TRAP;
                        endcase
                    end
                end
                EXEC_R: begin
                    ctrl.alu_sel = alu_sel_q;
                    state_d      = WB_R;
                end
`ifdef IMM_ALU_EN
                EXEC_I: begin
                    ctrl.alu_src = 1'b1;
                    ctrl.alu_sel = alu_sel_q;
                    state_d      = WB_R;
                end
`endif
                EXEC_ADDR: begin
                    ctrl.alu_src = 1'b1;
                    state_d      = (op_class_q == OPC_LOAD) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    ctrl.mem_read = 1'b1;
                    iord          = 1'b1;
                    if (mem_ready) state_d = WB_MEM;
                end
                MEM_WR: begin
                    ctrl.mem_write = 1'b1;
                    iord           = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                end
                EXEC_BR: begin
                    ctrl.alu_sel = ALU_SUB;
                    ctrl.branch  = 1'b1;
                    pc_branch    = zero;
                    instr_done   = 1'b1;
                    state_d      = FETCH;
                end
                WB_R: begin
                    ctrl.reg_write = 1'b1;
                    instr_done     = 1'b1;
                    state_d        = FETCH;
                end
                WB_MEM: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    instr_done      = 1'b1;
                    state_d         = FETCH;
                end
                TRAP: begin
                    illegal = 1'b1;
                end
                default: state_d = TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl (default build): per-instruction expected
// cycle traces are generated from instruction class and memory wait counts.
module tb_multicycle_ctrl;
    import control_defs::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    control_t   ctrl;
    logic       ir_write, pc_inc, pc_branch, iord, instr_done, illegal;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ctrl       (ctrl),
        .ir_write   (ir_write),
        .pc_inc     (pc_inc),
        .pc_branch  (pc_branch),
        .iord       (iord),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    // Observation vector: {alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_sel[3:0],
    //                      ir_write,pc_inc,pc_branch,iord,instr_done,illegal}
    logic [15:0] obs;
    assign obs = {ctrl.alu_src, ctrl.mem_to_reg, ctrl.reg_write, ctrl.mem_read,
                  ctrl.mem_write, ctrl.branch, ctrl.alu_sel,
                  ir_write, pc_inc, pc_branch, iord, instr_done, illegal};

    localparam logic [15:0] M_SRC  = 16'h8000;
    localparam logic [15:0] M_M2R  = 16'h4000;
    localparam logic [15:0] M_RW   = 16'h2000;
    localparam logic [15:0] M_MRD  = 16'h1000;
    localparam logic [15:0] M_MWR  = 16'h0800;
    localparam logic [15:0] M_BR   = 16'h0400;
    localparam logic [15:0] M_IRW  = 16'h0020;
    localparam logic [15:0] M_PCI  = 16'h0010;
    localparam logic [15:0] M_PCB  = 16'h0008;
    localparam logic [15:0] M_IORD = 16'h0004;
    localparam logic [15:0] M_DONE = 16'h0002;
    localparam logic [15:0] M_ILL  = 16'h0001;

    localparam logic [3:0] S_AND = 4'b0000;
    localparam logic [3:0] S_OR  = 4'b0001;
    localparam logic [3:0] S_ADD = 4'b0010;
    localparam logic [3:0] S_SUB = 4'b0110;

    function automatic logic [15:0] alu(input logic [3:0] s);
        return {6'b0, s, 6'b0};
    endfunction

    localparam logic [15:0] DEF = 16'h0080;

    typedef struct packed {
        logic        r;
        logic        rdy;
        logic        z;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [15:0] exp;
    } cyc_t;

    cyc_t  q[$];
    string q_tag[$];
    string cur_tag;
    int    cur_cyc;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic set_instr(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f7);
        cur_tag = tag;
        cur_cyc = 0;
        cur_op  = op;
        cur_f3  = f3;
        cur_f7  = f7;
    endtask

    task automatic push(input logic r, input logic rdy, input logic z, input logic [15:0] e);
        cyc_t c;
        cur_cyc++;
        c.r = r; c.rdy = rdy; c.z = z;
        c.op = cur_op; c.f3 = cur_f3; c.f7 = cur_f7;
        c.exp = e;
        q.push_back(c);
        q_tag.push_back($sformatf("%s#%0d.c%0d", cur_tag, q.size(), cur_cyc));
    endtask

    task automatic fetch(input int w);
        for (int i = 0; i < w; i++) push(1'b0, 1'b0, rb(), DEF | M_MRD);
        push(1'b0, 1'b1, rb(), DEF | M_MRD | M_IRW | M_PCI);
        push(1'b0, rb(), rb(), DEF);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) push(1'b1, rb(), rb(), DEF);
    endtask

    task automatic gen_r(input string tag, input logic [2:0] f3, input logic f7, input logic [3:0] sel, input int wf);
        set_instr(tag, 7'b0110011, f3, f7);
        fetch(wf);
        push(1'b0, rb(), rb(), alu(sel));
        push(1'b0, rb(), rb(), DEF | M_RW | M_DONE);
    endtask

    task automatic gen_lw(input int wf, input int wm);
        set_instr("lw", 7'b0000011, 3'b010, rb());
        fetch(wf);
        push(1'b0, rb(), rb(), DEF | M_SRC);
        for (int i = 0; i < wm; i++) push(1'b0, 1'b0, rb(), DEF | M_MRD | M_IORD);
        push(1'b0, 1'b1, rb(), DEF | M_MRD | M_IORD);
        push(1'b0, rb(), rb(), DEF | M_RW | M_M2R | M_DONE);
    endtask

    task automatic gen_sw(input int wf, input int wm, input int abort_at);
        set_instr(abort_at >= 0 ? "sw_rst" : "sw", 7'b0100011, 3'b010, rb());
        fetch(wf);
        push(1'b0, rb(), rb(), DEF | M_SRC);
        for (int i = 0; i < wm; i++) begin
            if (i == abort_at) begin
                do_reset(1);
                return;
            end
            push(1'b0, 1'b0, rb(), DEF | M_MWR | M_IORD);
        end
        push(1'b0, 1'b1, rb(), DEF | M_MWR | M_IORD | M_DONE);
    endtask

    task automatic gen_beq(input int wf, input logic z);
        set_instr("beq", 7'b1100011, 3'b000, rb());
        fetch(wf);
        push(1'b0, rb(), z, alu(S_SUB) | M_BR | M_DONE | (z ? M_PCB : 16'h0));
    endtask

    task automatic gen_trap(input string tag, input logic [6:0] op, input logic [2:0] f3, input int wf, input int nt);
        set_instr(tag, op, f3, rb());
        fetch(wf);
        for (int i = 0; i < nt; i++) push(1'b0, rb(), rb(), DEF | M_ILL);
        do_reset(1 + $urandom_range(0, 1));
    endtask

    task automatic gen_random();
        int k, wf;
        logic [2:0] f3;
        logic [6:0] op;
        k  = $urandom_range(0, 10);
        wf = $urandom_range(0, 2);
        case (k)
            0: gen_r("add", 3'b000, 1'b0, S_ADD, wf);
            1: gen_r("sub", 3'b000, 1'b1, S_SUB, wf);
            2: gen_r("and", 3'b111, rb(), S_AND, wf);
            3: gen_r("or",  3'b110, rb(), S_OR,  wf);
            4: gen_lw(wf, $urandom_range(0, 3));
            5: gen_sw(wf, $urandom_range(0, 3), -1);
            6: gen_beq(wf, rb());
            7: gen_sw(wf, 1 + $urandom_range(0, 2), 0);
            8: begin
                f3 = 3'($urandom_range(1, 5));
                gen_trap("r_badf3", 7'b0110011, f3, wf, $urandom_range(1, 6));
            end
            9: begin
                f3 = 3'($urandom_range(0, 7));
                if (f3 == 3'b010) f3 = 3'b011;
                gen_trap("ld_badf3", 7'b0000011, f3, wf, $urandom_range(1, 6));
            end
            default: begin
                op = 7'($urandom_range(0, 127));
                if (op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011)
                    op = 7'b1111111;
                gen_trap("bad_op", op, 3'($urandom_range(0, 7)), wf, $urandom_range(1, 6));
            end
        endcase
    endtask

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;

        set_instr("reset", 7'b0, 3'b0, 1'b0);
        do_reset(3);
        gen_r("add", 3'b000, 1'b0, S_ADD, 0);
        gen_lw(0, 3);
        gen_beq(0, 1'b1);
        gen_beq(0, 1'b0);
        gen_r("sub", 3'b000, 1'b1, S_SUB, 0);
        gen_r("or", 3'b110, 1'b0, S_OR, 0);
        gen_sw(0, 0, -1);
        gen_trap("op7f", 7'b1111111, 3'b000, 0, 12);
        gen_sw(1, 3, 2);
        gen_trap("ori", 7'b0010011, 3'b110, 0, 4);
        gen_trap("beq_badf3", 7'b1100011, 3'b001, 1, 3);
        for (int n = 0; n < 80; n++) gen_random();

        for (int i = 0; i < q.size(); i++) begin
            rst       = q[i].r;
            mem_ready = q[i].rdy;
            zero      = q[i].z;
            opcode    = q[i].op;
            funct3    = q[i].f3;
            funct7_5  = q[i].f7;
            @(negedge clk);
            check(q_tag[i], obs, q[i].exp);
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
